serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
- REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits; legal range 1..64.
- REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
- REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
- REQ-004 SHALL have port start  input  1  request to begin an addition of a, b, cin.
- REQ-005 SHALL have port a  input  WIDTH  addend A, sampled only on an accepted start.
- REQ-006 SHALL have port b  input  WIDTH  addend B, sampled only on an accepted start.
- REQ-007 SHALL have port cin  input  1  carry-in, sampled only on an accepted start.
- REQ-008 SHALL have port busy  output  1  high while an addition is in progress.
- REQ-009 SHALL have port done  output  1  single-cycle pulse when sum/cout are updated.
- REQ-010 SHALL have port sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
- REQ-011 SHALL have port cout  output  1  registered carry-out of the MSB.

Function
- REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
- REQ-013 IDLE: start=1 SHALL latch a, b, cin into shift registers, clear the bit counter and move to RUN.
- REQ-014 RUN: each cycle SHALL add the LSBs of both shift registers with the carry flop, shift the result bit in at the MSB of a partial-sum register, shift both operands right, and update the carry flop.
- REQ-015 RUN SHALL last exactly WIDTH cycles, then move to DONE; bit counter counts 0..WIDTH-1.
- REQ-016 DONE: SHALL assert done for that one cycle, with sum/cout loaded from the partial sum/carry on entry to DONE.
- REQ-017 From DONE: start=1 SHALL be accepted as in IDLE (back-to-back, next state RUN); otherwise next state IDLE.
- REQ-018 Latency: start accepted in cycle 0 SHALL give done=1 in cycle WIDTH+1; throughput one result per WIDTH+1 cycles.
- REQ-019 busy SHALL be 1 exactly in RUN.
- REQ-020 start while in RUN SHALL be ignored, with no effect on the current operation.
- REQ-021 sum/cout SHALL hold their value between done pulses and SHALL NOT change during RUN.
- REQ-022 a, b and cin SHALL be don't-care except in the cycle start is accepted.
- REQ-023 WIDTH=1 SHALL give one RUN cycle and done in cycle 2.

Reset
- REQ-024 rst_n=0 at a clock edge SHALL force state IDLE and clear busy, done, sum, cout, carry flop, counter, shift registers (and overflow when present).
- REQ-025 Reset SHALL take priority over start and SHALL abort an addition mid-RUN; no done is produced for the aborted operation.

Configuration
- REQ-026 Macro SERIAL_ADDER_OVF_EN defined: SHALL add port overflow  output  1, signed two's-complement overflow (carry into MSB XOR carry out of MSB), registered and updated with sum/cout.
- REQ-027 Macro SERIAL_ADDER_OVF_EN undefined: SHALL omit the overflow port and its logic; all other behaviour identical.

Structure
- REQ-028 Package serial_adder_pkg SHALL hold the FSM state enum typedef and the WIDTH legal-range constants.
- REQ-029 The per-bit add SHALL be one instantiated combinational sub-module full_adder (a, b, cin -> sum, carry).

Verification
- REQ-030 WIDTH=8, a=0xFF, b=0x01, cin=0, start in cycle 0 -> done in cycle 9, sum=0x00, cout=1; busy high cycles 1..8.
- REQ-031 WIDTH=8, a=0x7F, b=0x01, cin=0 with SERIAL_ADDER_OVF_EN -> sum=0x80, cout=0, overflow=1; a=0x80, b=0x80 -> sum=0x00, cout=1, overflow=1.
- REQ-032 start pulsed in cycle 4 of a running add (a=0x12, b=0x34) with different operands -> first result 0x46 unaffected, no extra done.
- REQ-033 rst_n low in cycle 5 of a run -> next cycle busy=0, sum=0, cout=0; no done for that operation.
- REQ-034 Back-to-back: start held high, operands 0x01+0x01 then 0xF0+0x0F cin=1 -> done in cycles 9 and 18, sums 0x02 then 0x00 with cout=1.
- REQ-035 WIDTH=1, all eight {a,b,cin} combinations -> done in cycle 2 each time, sum/cout match the full-adder truth table.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type and WIDTH legal range for serial_adder.
package serial_adder_pkg;
  localparam int WIDTH_MIN = 1;
  localparam int WIDTH_MAX = 64;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/serial_adder_full_adder.sv
// full_adder: single-bit combinational full adder used by serial_adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one bit per cycle LSB first; SERIAL_ADDER_OVF_EN adds a signed overflow output.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             overflow,
`endif
  output logic             cout
);
  localparam int CW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("serial_adder: WIDTH out of range");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic c_q, c_d, cout_q, cout_d, fa_s, fa_c, take, run, last;
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .cin(c_q), .sum(fa_s), .carry(fa_c));
  assign run  = state_q == RUN;
  assign take = start && !run;
  assign last = run && cnt_q == CW'(WIDTH - 1);
  // result bits enter at the MSB so after WIDTH shifts the LSB sits at bit 0
  always_comb begin
    state_d = take ? RUN : (run ? (last ? DONE : RUN) : IDLE);
    a_d     = take ? a : (run ? a_q >> 1 : a_q);
    b_d     = take ? b : (run ? b_q >> 1 : b_q);
    c_d     = take ? cin : (run ? fa_c : c_q);
    cnt_d   = take ? '0 : (run ? cnt_q + 1'b1 : cnt_q);
    ps_d    = take ? '0 : (run ? (ps_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1)) : ps_q);
    sum_d   = last ? ps_d : sum_q;
    cout_d  = last ? fa_c : cout_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end
`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  // c_q during the last RUN cycle is the carry into the MSB
  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (last) ovf_q <= c_q ^ fa_c;
  end
  assign overflow = ovf_q;
`endif
  assign busy = run;
  assign done = state_q == DONE;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench driving a WIDTH=8 and a WIDTH=1 serial_adder against an arithmetic model.
module tb_serial_adder;
  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          cyc;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic st[2];
  logic [63:0] ai[2], bi[2];
  logic ci[2];
  logic busy0, busy1, done0, done1, cout0, cout1;
  logic [7:0] sum0;
  logic [0:0] sum1;
  logic ovf0, ovf1;
  int cyc = 0, checks = 0, errors = 0;
  int W[2] = '{8, 1};
  exp_t q[2][$];
  exp_t last[2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  serial_adder #(.WIDTH(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ai[0][7:0]), .b(bi[0][7:0]), .cin(ci[0]),
    .busy(busy0), .done(done0), .sum(sum0),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow(ovf0),
`endif
    .cout(cout0)
  );
  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ai[1][0:0]), .b(bi[1][0:0]), .cin(ci[1]),
    .busy(busy1), .done(done1), .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
    .overflow(ovf1),
`endif
    .cout(cout1)
  );
`ifndef SERIAL_ADDER_OVF_EN
  assign ovf0 = 1'b0;
  assign ovf1 = 1'b0;
`endif
  function automatic void chk(string n, int d, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", n, d, cyc, act, exp);
    end
  endfunction
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic c, int at);
    exp_t e;
    logic [63:0] m;
    logic [64:0] t;
    m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
    t = {1'b0, a & m} + {1'b0, b & m} + 65'(c);
    e.sum  = t[63:0] & m;
    e.cout = t[w];
    e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
    e.cyc  = at;
    return e;
  endfunction
  always @(negedge clk) begin
    logic bv[2], dv[2], cv[2], ov[2];
    logic [63:0] sv[2];
    logic eb;
    exp_t e;
    bv = '{busy0, busy1};
    dv = '{done0, done1};
    cv = '{cout0, cout1};
    ov = '{ovf0, ovf1};
    sv = '{64'(sum0), 64'(sum1)};
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        q[d].delete();
        last[d] = '{64'd0, 1'b0, 1'b0, 0};
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        eb = q[d].size() > 0 && cyc >= q[d][0].cyc - W[d] && cyc < q[d][0].cyc;
        chk("busy", d, 64'(bv[d]), 64'(eb));
        if (dv[d]) begin
          if (q[d].size() == 0) chk("unexpected_done", d, 64'd1, 64'd0);
          else begin
            e = q[d].pop_front();
            chk("done_cycle", d, 64'(cyc), 64'(e.cyc));
            chk("sum", d, sv[d], e.sum);
            chk("cout", d, 64'(cv[d]), 64'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            chk("overflow", d, 64'(ov[d]), 64'(e.ovf));
`endif
            last[d] = e;
          end
        end else begin
          chk("sum_hold", d, sv[d], last[d].sum);
          chk("cout_hold", d, 64'(cv[d]), 64'(last[d].cout));
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovf_hold", d, 64'(ov[d]), 64'(last[d].ovf));
`endif
        end
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(int d, logic [63:0] a, logic [63:0] b, logic c);
    st[d] = 1'b1;
    ai[d] = a;
    bi[d] = b;
    ci[d] = c;
    q[d].push_back(model(W[d], a, b, c, cyc + W[d] + 1));
    step();
    st[d] = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("drain", 0, 64'(n < 200), 64'd1);
  endtask
  initial begin
    st = '{1'b0, 1'b0};
    ai = '{64'd0, 64'd0};
    bi = '{64'd0, 64'd0};
    ci = '{1'b0, 1'b0};
    repeat (2) step();
    rst_n = 1'b1;
    step();
    issue(0, 64'hFF, 64'h01, 1'b0);
    wait_idle();
    issue(0, 64'h7F, 64'h01, 1'b0);
    wait_idle();
    issue(0, 64'h80, 64'h80, 1'b0);
    wait_idle();
    issue(0, 64'h12, 64'h34, 1'b0);
    repeat (3) step();
    st[0] = 1'b1;
    ai[0] = 64'h55;
    bi[0] = 64'hAA;
    ci[0] = 1'b1;
    step();
    st[0] = 1'b0;
    wait_idle();
    issue(0, 64'h3C, 64'h5A, 1'b1);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (3) step();
    wait_idle();
    st[0] = 1'b1;
    ai[0] = 64'h01;
    bi[0] = 64'h01;
    ci[0] = 1'b0;
    q[0].push_back(model(8, 64'h01, 64'h01, 1'b0, cyc + 9));
    repeat (9) step();
    ai[0] = 64'hF0;
    bi[0] = 64'h0F;
    ci[0] = 1'b1;
    q[0].push_back(model(8, 64'hF0, 64'h0F, 1'b1, cyc + 9));
    step();
    st[0] = 1'b0;
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      issue(1, 64'((i >> 2) & 1), 64'((i >> 1) & 1), i[0]);
      wait_idle();
    end
    for (int i = 0; i < 40; i++) begin
      for (int d = 0; d < 2; d++) begin
        st[d] = 1'b1;
        ai[d] = {$urandom, $urandom};
        bi[d] = {$urandom, $urandom};
        ci[d] = 1'($urandom);
        q[d].push_back(model(W[d], ai[d], bi[d], ci[d], cyc + W[d] + 1));
      end
      step();
      st = '{1'b0, 1'b0};
      repeat ($urandom_range(0, 3)) step();
      st[0] = 1'b1;
      ai[0] = {$urandom, $urandom};
      step();
      st[0] = 1'b0;
      wait_idle();
    end
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
